rv_fetch_buf: RTL and testbench
===============================

# rv_fetch_buf

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the bare PC register, PC+4 adder and IF/ID register with three pieces: a PC generator, a one-outstanding-request synchronous IMEM interface, and a DEPTH-entry instruction queue. Decode consumes the queue through a valid/ready handshake. Execute or decode redirect the fetch stream with a single-cycle redirect pulse, which flushes everything younger than the redirect.

## Interface
- XLEN, 32, PC/address width (≥ 16)
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address; bits [1:0] must be 0

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low; sampled only on the rising edge of clk
- imem_req  out  1  fetch request this cycle
- imem_addr  out  XLEN  word-aligned fetch address, valid when imem_req=1
- imem_rdata  in  32  instruction, valid in the cycle after an accepted imem_req
- redirect_valid  in  1  flush and restart fetch (branch/jump resolution)
- redirect_pc  in  XLEN  restart address; bits [1:0] ignored and treated as 0
- d_valid  out  1  queue head valid
- d_ready  in  1  decode accepts the head
- d_instr  out  32  head instruction
- d_pc  out  XLEN  head PC
- d_pc_p4  out  XLEN  head PC + 4 (mod 2^XLEN)
- d_pred  out  1  head was a JAL already followed by fetch (predecode)
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- State:
  - fpc: next fetch PC
  - inflight: 1 bit
  - inflight_pc: PC of the outstanding request
  - circular queue with rd_ptr/wr_ptr and count; each entry holds {instr, pc, pred}
- pop = d_valid & d_ready. d_valid = (count != 0). Head fields come directly from the queue (registered storage; no bypass of imem_rdata).
- push = inflight & ~redirect_valid. The entry written is {imem_rdata, inflight_pc, pred_hit}.
- Request credit: imem_req = ~redirect_valid & (count + inflight − pop < DEPTH).
- On an issued request:
  - inflight ← 1
  - inflight_pc ← imem_addr
  - fpc ← imem_addr + 4
- With no request, inflight ← 0.
- imem_addr = fpc, except when the predecode override is active (see Configuration).
- Redirect has priority over push, pop and request:
  - count, rd_ptr, wr_ptr ← 0
  - inflight ← 0; the response arriving this cycle is discarded
  - fpc ← {redirect_pc[XLEN-1:2], 2'b00}
  - imem_req = 0 this cycle
- Push and pop in the same cycle leave count unchanged. The credit rule guarantees a push never occurs with count = DEPTH.
- Pointers wrap modulo DEPTH. PC arithmetic wraps modulo 2^XLEN.
- Reset (rst_n low at an edge), also when asserted mid-stream:
  - fpc ← RESET_PC
  - inflight, count, pointers ← 0
  - outputs: d_valid=0, imem_req=0, count=0, d_pred=0, d_instr/d_pc/d_pc_p4 = 0
  - in-flight data is dropped
  - imem_req may assert in the first cycle after rst_n is sampled high.

## Timing
- Request issued in cycle t → imem_rdata sampled in t+1 → d_valid in t+2 (empty queue). Minimum fetch-to-decode latency: 2 cycles.
- Redirect in cycle t → request to the target in t+1 → target at the queue head with d_valid=1 in t+3.
- Steady state with d_ready held high: one instruction per cycle, count = 1, inflight = 1.
- d_ready low: requests continue until count + inflight = DEPTH, then imem_req=0. The first request after d_ready rises is issued in the same cycle as the pop.
- Outputs other than imem_req/imem_addr are functions of registers only.

## Configuration
- RV_FETCH_JAL_PREDECODE_EN
  - Defined:
    - When push = 1 and imem_rdata[6:0] = 7'h6F (JAL), pred_hit = 1.
    - If a request is issued that cycle, imem_addr = inflight_pc + sign-extended J-immediate (imem_rdata[31], [19:12], [20], [30:21], 0) instead of fpc; fpc ← that target + 4.
    - The sequential path costs no bubble. Decode must suppress its own JAL redirect when d_pred = 1.
  - Undefined: pred_hit = 0, d_pred is constant 0, imem_addr = fpc always.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0x100, d_ready=1.
  - Required: imem_addr 0x100, 0x104, 0x108 on consecutive cycles; first d_valid two cycles after the first request with d_pc=0x100 and d_pc_p4=0x104.
- Backpressure, DEPTH=4:
  - Stimulus: d_ready=0.
  - Required: exactly 4 requests, then count=4 with imem_req=0 held; raising d_ready pops 0x100..0x10C in order with no gaps or duplicates.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc=0x203 while count=3 and inflight=1.
  - Required: next cycle count=0 and imem_addr=0x200; d_pc=0x200 appears 3 cycles after the redirect; the stale response is never enqueued.
- Simultaneous events:
  - Stimulus: redirect asserted in the same cycle as pop and push.
  - Required: count=0 afterwards and the redirect wins.
- Reset mid-stream:
  - Stimulus: rst_n low for 1 edge with count=2.
  - Required: all outputs return to reset values; fetch restarts at RESET_PC.
- Predecode, macro defined:
  - Stimulus: JAL with imm=+0x40 fetched at 0x104.
  - Required: the next imem_addr is 0x144; the JAL entry has d_pred=1; the instruction at 0x108 is never fetched. With the macro undefined: 0x108 is fetched and d_pred=0.

Source files
------------

// File: rtl/rv_fetch_buf.sv
// rv_fetch_buf: instruction-fetch front end for the RV32 pipeline.
// A PC generator drives a synchronous IMEM port that allows one request
// in flight; responses land in a DEPTH-entry circular queue that decode
// drains through a valid/ready handshake. A redirect pulse flushes the
// queue and the outstanding request, then restarts fetch at the target.
//
// Optional feature, selected by the RV_FETCH_JAL_PREDECODE_EN macro:
// JAL instructions are recognised as they arrive from IMEM and fetch is
// steered to the jump target in the same cycle. The queue entry is tagged
// with d_pred so that decode can skip its own JAL redirect.
module rv_fetch_buf #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [31:0]                d_instr,
    output logic [XLEN-1:0]            d_pc,
    output logic [XLEN-1:0]            d_pc_p4,
    output logic                       d_pred,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // One extra bit so that count + inflight cannot overflow in the credit check.
    localparam int OW = CW + 1;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_inflightPc;
    logic            r_inflight;
    logic [PW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_count;

    logic [31:0]     r_qInstr [DEPTH];
    logic [XLEN-1:0] r_qPc    [DEPTH];

    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_req;
    logic            w_predHit;
    logic [OW-1:0]   w_occ;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_nextFpc;

    // The low two bits of the redirect target are dropped, so they are collected here.
    logic            w_unusedBits;
    assign w_unusedBits = ^redirect_pc[1:0];

`ifdef RV_FETCH_JAL_PREDECODE_EN
    logic [20:0]     w_jImm21;
    logic [XLEN-1:0] w_jImm;
    assign w_jImm21 = {imem_rdata[31], imem_rdata[19:12], imem_rdata[20],
                       imem_rdata[30:21], 1'b0};
    assign w_jImm   = XLEN'($signed(w_jImm21));
`endif

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & d_ready;
    assign w_push  = r_inflight & ~redirect_valid;

    // Occupancy after this cycle's pop, counting the response still in flight.
    assign w_occ = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
    assign w_req = rst_n & ~redirect_valid & (w_occ < OW'(DEPTH));

    // Fetch address selection: sequential PC, or a JAL target found in the arriving word.
    always_comb begin
        w_predHit = 1'b0;
        w_addr    = r_fpc;
`ifdef RV_FETCH_JAL_PREDECODE_EN
        w_predHit = w_push & (imem_rdata[6:0] == 7'h6F);
        if (w_predHit) begin
            w_addr = r_inflightPc + w_jImm;
        end
`endif
    end

    // Next sequential PC; a JAL seen while the queue is full still retargets
    // fpc so the tagged entry is never followed by a fall-through fetch.
    always_comb begin
        if (w_req) begin
            w_nextFpc = w_addr + XLEN'(4);
        end else if (w_predHit) begin
            w_nextFpc = w_addr;
        end else begin
            w_nextFpc = r_fpc;
        end
    end

    // Control state: PC generator, outstanding request and queue pointers; redirect wins over all traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc        <= RESET_PC;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_count      <= '0;
        end else if (redirect_valid) begin
            r_fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflightPc <= w_addr;
            end
            r_fpc <= w_nextFpc;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage: the response word and its PC are captured at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qInstr[r_wrPtr] <= imem_rdata;
            r_qPc[r_wrPtr]    <= r_inflightPc;
        end
    end

`ifdef RV_FETCH_JAL_PREDECODE_EN
    logic r_qPred [DEPTH];

    // Predecode tag storage, written alongside the instruction.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qPred[r_wrPtr] <= w_predHit;
        end
    end

    assign d_pred = w_valid & r_qPred[r_rdPtr];
`else
    assign d_pred = 1'b0;
`endif

    // Head fields are forced to zero when the queue is empty so reset and flush look clean.
    assign d_valid   = w_valid;
    assign d_instr   = w_valid ? r_qInstr[r_rdPtr] : 32'h0;
    assign d_pc      = w_valid ? r_qPc[r_rdPtr] : '0;
    assign d_pc_p4   = w_valid ? (r_qPc[r_rdPtr] + XLEN'(4)) : '0;
    assign count     = r_count;
    assign imem_req  = w_req;
    assign imem_addr = w_addr;

endmodule

// File: tb/tb_rv_fetch_buf.sv
// tb_rv_fetch_buf: directed self-checking bench for rv_fetch_buf
// (DEPTH=4, RESET_PC=0x100). A small IMEM model answers every request
// one cycle later with a word derived from the address. Inputs change and
// outputs are sampled just after the falling edge.
module tb_rv_fetch_buf;

    localparam logic [31:0] JAL_WORD = 32'h0400006F;
`ifdef RV_FETCH_JAL_PREDECODE_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc_p4;
    logic        d_pred;
    logic [2:0]  count;

    logic [31:0] rspAddr;
    logic        jalMode;
    int          testsRun;
    int          testsFailed;

    rv_fetch_buf #(
        .XLEN(32),
        .DEPTH(4),
        .RESET_PC(32'h100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .d_instr(d_instr),
        .d_pc(d_pc),
        .d_pc_p4(d_pc_p4),
        .d_pred(d_pred),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM contents: ADDI-opcode words tagged with the address, plus a JAL (+0x40) at 0x104 when enabled.
    function automatic logic [31:0] instrAt(input logic [31:0] a, input logic jal);
        if (jal && a == 32'h104) return JAL_WORD;
        return {a[19:0], 12'h013};
    endfunction

    // IMEM model: the address seen at an edge is answered during the following cycle.
    always @(posedge clk) rspAddr <= imem_addr;
    assign imem_rdata = instrAt(rspAddr, jalMode);

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle;
        @(negedge clk);
        #1;
    endtask

    // Holds rst_n low across two rising edges and returns at a falling edge.
    task automatic doReset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        d_ready = ready;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic waitForReq(output bit ok);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            waitCycle();
            n++;
        end
        ok = (imem_req === 1'b1);
    endtask

    task automatic waitForCount(input logic [2:0] target, output bit ok);
        int n;
        n = 0;
        while (count !== target && n < 12) begin
            waitCycle();
            n++;
        end
        ok = (count === target);
    endtask

    task automatic test_reset;
        doReset(1'b1);
        #1;
        testsRun++; if (d_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_d_valid: got %0h want 0", d_valid); end
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_imem_req: got %0h want 0", imem_req); end
        testsRun++; if (count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        testsRun++; if (d_pred !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_d_pred: got %0h want 0", d_pred); end
        testsRun++; if (d_instr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_d_instr: got %h want 0", d_instr); end
        testsRun++; if (d_pc !== 32'h0 || d_pc_p4 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_d_pc: got %h/%h want 0/0", d_pc, d_pc_p4); end
    endtask

    task automatic test_stream;
        bit ok;
        logic [31:0] expAddr;
        logic [31:0] expPc;
        doReset(1'b1);
        rst_n = 1'b1;
        #1;
        waitForReq(ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL stream_first_req: got timeout want imem_req=1"); end
        for (int i = 0; i < 6; i++) begin
            expAddr = 32'h100 + 32'(4 * i);
            testsRun++; if (imem_req !== 1'b1 || imem_addr !== expAddr) begin testsFailed++; $display("[TB] FAIL stream_addr[%0d]: got req=%0h addr=%h want req=1 addr=%h", i, imem_req, imem_addr, expAddr); end
            if (i < 2) begin
                testsRun++; if (d_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_early_valid[%0d]: got %0h want 0", i, d_valid); end
            end else begin
                expPc = 32'h100 + 32'(4 * (i - 2));
                testsRun++; if (d_valid !== 1'b1 || d_pc !== expPc || d_pc_p4 !== expPc + 32'h4) begin testsFailed++; $display("[TB] FAIL stream_head[%0d]: got v=%0h pc=%h p4=%h want v=1 pc=%h p4=%h", i, d_valid, d_pc, d_pc_p4, expPc, expPc + 32'h4); end
                testsRun++; if (d_instr !== instrAt(expPc, 1'b0)) begin testsFailed++; $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, d_instr, instrAt(expPc, 1'b0)); end
                testsRun++; if (count !== 3'd1) begin testsFailed++; $display("[TB] FAIL stream_count[%0d]: got %0d want 1", i, count); end
            end
            waitCycle();
        end
    endtask

    task automatic test_backpressure;
        int nReq;
        logic [31:0] expPc;
        doReset(1'b0);
        rst_n = 1'b1;
        #1;
        nReq = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_req === 1'b1) begin
                testsRun++; if (imem_addr !== 32'h100 + 32'(4 * nReq)) begin testsFailed++; $display("[TB] FAIL bp_req_addr[%0d]: got %h want %h", nReq, imem_addr, 32'h100 + 32'(4 * nReq)); end
                nReq++;
            end
            waitCycle();
        end
        testsRun++; if (nReq != 4) begin testsFailed++; $display("[TB] FAIL bp_req_total: got %0d want 4", nReq); end
        testsRun++; if (count !== 3'd4 || imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_full: got count=%0d req=%0h want count=4 req=0", count, imem_req); end
        d_ready = 1'b1;
        #1;
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin testsFailed++; $display("[TB] FAIL bp_resume_req: got req=%0h addr=%h want req=1 addr=00000110", imem_req, imem_addr); end
        for (int j = 0; j < 7; j++) begin
            expPc = 32'h100 + 32'(4 * j);
            testsRun++; if (d_valid !== 1'b1 || d_pc !== expPc) begin testsFailed++; $display("[TB] FAIL bp_drain[%0d]: got v=%0h pc=%h want v=1 pc=%h", j, d_valid, d_pc, expPc); end
            waitCycle();
        end
    endtask

    task automatic test_redirect;
        bit ok;
        doReset(1'b0);
        rst_n = 1'b1;
        #1;
        waitForCount(3'd3, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL redir_setup: got count=%0d want 3", count); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        #1;
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL redir_req_blocked: got %0h want 0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        testsRun++; if (count !== 3'd0 || d_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL redir_flush: got count=%0d v=%0h want 0/0", count, d_valid); end
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin testsFailed++; $display("[TB] FAIL redir_target: got req=%0h addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
        waitCycle();
        testsRun++; if (d_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL redir_t2_valid: got %0h want 0", d_valid); end
        waitCycle();
        testsRun++; if (d_valid !== 1'b1 || d_pc !== 32'h200 || count !== 3'd1) begin testsFailed++; $display("[TB] FAIL redir_head: got v=%0h pc=%h count=%0d want v=1 pc=00000200 count=1", d_valid, d_pc, count); end
        testsRun++; if (d_instr !== instrAt(32'h200, 1'b0)) begin testsFailed++; $display("[TB] FAIL redir_instr: got %h want %h", d_instr, instrAt(32'h200, 1'b0)); end
    endtask

    task automatic test_simultaneous;
        int n;
        doReset(1'b1);
        rst_n = 1'b1;
        #1;
        n = 0;
        while (d_valid !== 1'b1 && n < 10) begin
            waitCycle();
            n++;
        end
        testsRun++; if (d_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL simul_setup: got d_valid=%0h want 1", d_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL simul_req_blocked: got %0h want 0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        testsRun++; if (count !== 3'd0 || d_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL simul_flush: got count=%0d v=%0h want 0/0", count, d_valid); end
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin testsFailed++; $display("[TB] FAIL simul_target: got req=%0h addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        waitCycle();
        testsRun++; if (imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL simul_pc_wrap: got %h want 00000000", imem_addr); end
        waitCycle();
        testsRun++; if (d_valid !== 1'b1 || d_pc !== 32'hFFFF_FFFC || d_pc_p4 !== 32'h0) begin testsFailed++; $display("[TB] FAIL simul_head: got v=%0h pc=%h p4=%h want v=1 pc=fffffffc p4=00000000", d_valid, d_pc, d_pc_p4); end
        waitCycle();
        testsRun++; if (d_valid !== 1'b1 || d_pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL simul_next: got v=%0h pc=%h want v=1 pc=00000000", d_valid, d_pc); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        doReset(1'b0);
        rst_n = 1'b1;
        #1;
        waitForCount(3'd2, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL rmid_setup: got count=%0d want 2", count); end
        rst_n = 1'b0;
        waitCycle();
        testsRun++; if (d_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_ctrl: got v=%0h count=%0d req=%0h want 0/0/0", d_valid, count, imem_req); end
        testsRun++; if (d_instr !== 32'h0 || d_pc !== 32'h0 || d_pc_p4 !== 32'h0 || d_pred !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_head: got instr=%h pc=%h p4=%h pred=%0h want zeros", d_instr, d_pc, d_pc_p4, d_pred); end
        rst_n = 1'b1;
        d_ready = 1'b1;
        #1;
        waitForReq(ok);
        testsRun++; if (!ok || imem_addr !== 32'h100) begin testsFailed++; $display("[TB] FAIL rmid_restart: got req=%0h addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
        waitCycle();
        waitCycle();
        testsRun++; if (d_valid !== 1'b1 || d_pc !== 32'h100) begin testsFailed++; $display("[TB] FAIL rmid_head_after: got v=%0h pc=%h want v=1 pc=00000100", d_valid, d_pc); end
    endtask

    task automatic test_predecode;
        bit ok;
        logic [31:0] expAddr;
        logic [31:0] expPc;
        jalMode = 1'b1;
        doReset(1'b1);
        rst_n = 1'b1;
        #1;
        waitForReq(ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL pred_first_req: got timeout want imem_req=1"); end
        for (int i = 0; i < 5; i++) begin
            if (i < 2 || !PRED_EN) expAddr = 32'h100 + 32'(4 * i);
            else expAddr = 32'h144 + 32'(4 * (i - 2));
            testsRun++; if (imem_req !== 1'b1 || imem_addr !== expAddr) begin testsFailed++; $display("[TB] FAIL pred_addr[%0d]: got req=%0h addr=%h want req=1 addr=%h", i, imem_req, imem_addr, expAddr); end
            if (i == 3) begin
                testsRun++; if (d_valid !== 1'b1 || d_pc !== 32'h104 || d_instr !== JAL_WORD) begin testsFailed++; $display("[TB] FAIL pred_jal_head: got v=%0h pc=%h instr=%h want v=1 pc=00000104 instr=%h", d_valid, d_pc, d_instr, JAL_WORD); end
                testsRun++; if (d_pred !== PRED_EN) begin testsFailed++; $display("[TB] FAIL pred_jal_tag: got %0h want %0h", d_pred, PRED_EN); end
            end
            if (i == 4) begin
                expPc = PRED_EN ? 32'h144 : 32'h108;
                testsRun++; if (d_valid !== 1'b1 || d_pc !== expPc || d_pred !== 1'b0) begin testsFailed++; $display("[TB] FAIL pred_after_jal: got v=%0h pc=%h pred=%0h want v=1 pc=%h pred=0", d_valid, d_pc, d_pred, expPc); end
            end
            waitCycle();
        end
        jalMode = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        jalMode = 1'b0;
        rst_n = 1'b0;
        d_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        rspAddr = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_reset_mid();
        test_predecode();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
